// File: rtl/life_grid_engine_if.sv
// Strobe and status bundle between the game-control FSM (master) and the cell-array engine (slave).
interface life_grid_engine_if #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned GEN_W = 8
);
    localparam int unsigned N = ROWS * COLS;

    logic             loadData;
    logic             readData;
    logic             writeout;
    logic             restart;
    logic             load_bit;
    logic [N-1:0]     cells;
    logic [7:0]       scan_idx;
    logic             scan_done;
    logic [GEN_W-1:0] gen_count;
    logic             loseSig;
    logic             early_commit;

    modport master (
        output loadData, readData, writeout, restart, load_bit,
        input  cells, scan_idx, scan_done, gen_count, loseSig, early_commit
    );

    modport slave (
        input  loadData, readData, writeout, restart, load_bit,
        output cells, scan_idx, scan_done, gen_count, loseSig, early_commit
    );
endinterface

// File: rtl/life_grid_engine.sv
// Toroidal Game-of-Life board: serial load, one-cell-per-clock B3/S23 scan into nxt, commit on writeout.
module life_grid_engine #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned GEN_W = 8
) (
    input logic               clka,
    input logic               rst_n,
    life_grid_engine_if.slave bus
);
    localparam int unsigned N    = ROWS * COLS;
    localparam logic [7:0]  LAST = 8'(N - 1);

    logic [N-1:0]     cur;
    logic [N-1:0]     nxt;
    logic [7:0]       load_ptr;
    logic [7:0]       scan_idx;
    logic             scan_done;
    logic [GEN_W-1:0] gen_count;
    logic             loseSig;
    logic             early_commit;

    logic [7:0]       nb_idx [8];
    logic [3:0]       nb_count;
    logic             next_bit;

    // Neighbour addresses wrap explicitly at the edges so non-power-of-two boards also work.
    always_comb begin
        int unsigned r, c, rm, rp, cm, cp;
        r  = 32'(scan_idx) / COLS;
        c  = 32'(scan_idx) % COLS;
        rm = (r == 0)        ? ROWS - 1 : r - 1;
        rp = (r == ROWS - 1) ? 0        : r + 1;
        cm = (c == 0)        ? COLS - 1 : c - 1;
        cp = (c == COLS - 1) ? 0        : c + 1;

        nb_idx[0] = 8'(rm * COLS + cm);
        nb_idx[1] = 8'(rm * COLS + c);
        nb_idx[2] = 8'(rm * COLS + cp);
        nb_idx[3] = 8'(r  * COLS + cm);
        nb_idx[4] = 8'(r  * COLS + cp);
        nb_idx[5] = 8'(rp * COLS + cm);
        nb_idx[6] = 8'(rp * COLS + c);
        nb_idx[7] = 8'(rp * COLS + cp);

        nb_count = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            nb_count = nb_count + 4'(cur[nb_idx[k]]);
        end
        next_bit = (nb_count == 4'd3) | (cur[scan_idx] & (nb_count == 4'd2));
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= '0;
            nxt          <= '0;
            load_ptr     <= '0;
            scan_idx     <= '0;
            scan_done    <= 1'b0;
            gen_count    <= '0;
            loseSig      <= 1'b0;
            early_commit <= 1'b0;
        end else if (bus.restart) begin
            cur          <= '0;
            nxt          <= '0;
            load_ptr     <= '0;
            scan_idx     <= '0;
            scan_done    <= 1'b0;
            gen_count    <= '0;
            loseSig      <= 1'b0;
            early_commit <= 1'b0;
        end else if (bus.loadData) begin
            cur[load_ptr] <= bus.load_bit;
            load_ptr      <= (load_ptr == LAST) ? 8'd0 : load_ptr + 8'd1;
            scan_idx      <= '0;
            scan_done     <= 1'b0;
        end else if (bus.writeout) begin
            if (scan_done) begin
                cur       <= nxt;
                gen_count <= gen_count + 1'b1;
                loseSig   <= (nxt == '0) | (nxt == cur);
                scan_done <= 1'b0;
            end else begin
                early_commit <= 1'b1;
            end
        end else if (bus.readData && !scan_done) begin
            nxt[scan_idx] <= next_bit;
            if (scan_idx == LAST) begin
                scan_idx  <= '0;
                scan_done <= 1'b1;
            end else begin
                scan_idx  <= scan_idx + 8'd1;
            end
        end
    end

    assign bus.cells        = cur;
    assign bus.scan_idx     = scan_idx;
    assign bus.scan_done    = scan_done;
    assign bus.gen_count    = gen_count;
    assign bus.loseSig      = loseSig;
    assign bus.early_commit = early_commit;
endmodule
